hvac_actuator_ctrl: RTL and testbench

Downstream stage of the air-conditioning controller.
- Consumes its `heat`/`cool` request bits and drives the physical heater, compressor and fan.
- Enforces fan lead/trail purge, a minimum run time and a minimum off time (anti-short-cycle).
- Never energises heater and compressor together.
- Fully synthesizable: integer cycle counters only, no real arithmetic.

---
 rtl/hvac_actuator_ctrl.sv | 154 +++++++++++++++
 tb/tb_hvac_actuator_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hvac_actuator_ctrl.sv
// Actuator sequencer: fan lead/trail purge, minimum on/off timing and heat/cool interlock.
// Optional RUN-entry counter enabled by defining HVAC_START_CNT_EN.
module hvac_actuator_ctrl #(
    parameter int MIN_ON_CYC    = 8,
    parameter int MIN_OFF_CYC   = 6,
    parameter int FAN_LEAD_CYC  = 2,
    parameter int FAN_TRAIL_CYC = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        heat,
    input  logic        cool,
    output logic        heater_on,
    output logic        compressor_on,
    output logic        fan_on,
    output logic        fault,
    output logic [2:0]  state
`ifdef HVAC_START_CNT_EN
    ,
    output logic [15:0] start_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_TRAIL = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEAD_LAST_C  = CNT_W'(FAN_LEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST_C    = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] ON_SAT_C     = CNT_W'(MIN_ON_CYC);
    localparam logic [CNT_W-1:0] TRAIL_LAST_C = CNT_W'(FAN_TRAIL_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST_C   = CNT_W'(MIN_OFF_CYC - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mode_r;
    logic             mode_nxt_s;
    logic             valid_req_s;
    logic             mode_req_s;

    // Both requests high is treated as no request; mode request is the one matching the latched mode.
    assign valid_req_s = heat ^ cool;
    assign mode_req_s  = (mode_r == MODE_COOL) ? (cool & ~heat) : (heat & ~cool);

    // Next-state and next-mode decision.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_req_s) begin
                    state_nxt_s = ST_LEAD;
                    mode_nxt_s  = cool ? MODE_COOL : MODE_HEAT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (cnt_r == LEAD_LAST_C) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LEAD;
                end
            end
            ST_RUN: begin
                if (!mode_req_s && (cnt_r >= ON_LAST_C)) begin
                    state_nxt_s = ST_TRAIL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_TRAIL: begin
                if (cnt_r == TRAIL_LAST_C) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_TRAIL;
                end
            end
            ST_HOLD: begin
                if (cnt_r == OFF_LAST_C) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                mode_nxt_s  = MODE_HEAT;
            end
        endcase
    end

    // State, phase counter, mode latch and drives decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO_C;
            mode_r        <= MODE_HEAT;
            fan_on        <= 1'b0;
            heater_on     <= 1'b0;
            compressor_on <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            fault   <= heat & cool;
            if (state_nxt_s != state_r) begin
                cnt_r <= CNT_ZERO_C;
            end else if (state_r == ST_IDLE) begin
                cnt_r <= CNT_ZERO_C;
            end else if ((state_r == ST_RUN) && (cnt_r == ON_SAT_C)) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE_C;
            end
            fan_on        <= (state_nxt_s == ST_LEAD) || (state_nxt_s == ST_RUN) ||
                             (state_nxt_s == ST_TRAIL);
            heater_on     <= (state_nxt_s == ST_RUN) && (mode_nxt_s == MODE_HEAT);
            compressor_on <= (state_nxt_s == ST_RUN) && (mode_nxt_s == MODE_COOL);
        end
    end

    assign state = state_r;

`ifdef HVAC_START_CNT_EN
    logic [15:0] start_cnt_r;

    // Saturating count of LEAD-to-RUN transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_cnt_r <= 16'h0000;
        end else if ((state_r == ST_LEAD) && (state_nxt_s == ST_RUN) &&
                     (start_cnt_r != 16'hFFFF)) begin
            start_cnt_r <= start_cnt_r + 16'h0001;
        end else begin
            start_cnt_r <= start_cnt_r;
        end
    end

    assign start_count = start_cnt_r;
`endif

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Self-checking bench for hvac_actuator_ctrl: directed scenarios plus randomized requests
// checked every cycle against a countdown-timer model of the actuator sequence.
module tb_hvac_actuator_ctrl;

    localparam int MIN_ON    = 8;
    localparam int MIN_OFF   = 6;
    localparam int FAN_LEAD  = 2;
    localparam int FAN_TRAIL = 4;

    // Phase codes as exposed on the debug port.
    localparam int P_IDLE  = 0;
    localparam int P_LEAD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_TRAIL = 3;
    localparam int P_HOLD  = 4;

    logic       clk;
    logic       reset;
    logic       heat;
    logic       cool;
    logic       heater_on;
    logic       compressor_on;
    logic       fan_on;
    logic       fault;
    logic [2:0] state;
`ifdef HVAC_START_CNT_EN
    logic [15:0] start_count;
`endif

    int n_checks;
    int n_err;

    // Model: current phase, cycles remaining in timed phases, cycles spent in RUN.
    int m_ph;
    int m_rem;
    int m_age;
    int m_cool;
    int m_fault;
    int m_starts;

    logic [1:0] pat;

    hvac_actuator_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .heat          (heat),
        .cool          (cool),
        .heater_on     (heater_on),
        .compressor_on (compressor_on),
        .fan_on        (fan_on),
        .fault         (fault),
        .state         (state)
`ifdef HVAC_START_CNT_EN
        ,
        .start_count   (start_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_rem   = 0;
        m_age   = 0;
        m_cool  = 0;
        m_fault = 0;
        m_starts = 0;
    endtask

    // Advance the model by one clock edge given the sampled requests.
    task automatic model_step(input int h, input int c);
        int want;
        m_fault = h & c;
        case (m_ph)
            P_IDLE: begin
                if ((h ^ c) == 1) begin
                    m_ph   = P_LEAD;
                    m_cool = c;
                    m_rem  = FAN_LEAD;
                end
            end
            P_LEAD: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph  = P_RUN;
                    m_age = 0;
                    if (m_starts < 65535) m_starts++;
                end
            end
            P_RUN: begin
                m_age++;
                want = (m_cool != 0) ? (c & ~h & 1) : (h & ~c & 1);
                if (want == 0 && m_age >= MIN_ON) begin
                    m_ph  = P_TRAIL;
                    m_rem = FAN_TRAIL;
                end
            end
            P_TRAIL: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph  = P_HOLD;
                    m_rem = MIN_OFF;
                end
            end
            P_HOLD: begin
                m_rem--;
                if (m_rem == 0) m_ph = P_IDLE;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_model();
        chk("state", int'(state), m_ph);
        chk("fan_on", int'(fan_on), (m_ph == P_LEAD || m_ph == P_RUN || m_ph == P_TRAIL) ? 1 : 0);
        chk("heater_on", int'(heater_on), (m_ph == P_RUN && m_cool == 0) ? 1 : 0);
        chk("compressor_on", int'(compressor_on), (m_ph == P_RUN && m_cool != 0) ? 1 : 0);
        chk("fault", int'(fault), m_fault);
        chk("interlock", int'(heater_on & compressor_on), 0);
`ifdef HVAC_START_CNT_EN
        chk("start_count", int'(start_count), m_starts);
`endif
    endtask

    // One clock: inputs already set at the previous falling edge, outputs checked at the next.
    task automatic step_cycle(input logic h, input logic c);
        heat = h;
        cool = c;
        @(posedge clk);
        model_step(int'(h), int'(c));
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_out(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0);
    endtask

    // Reset asserted between edges: outputs must clear before the next rising edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("arst_fan", int'(fan_on), 0);
        chk("arst_heater", int'(heater_on), 0);
        chk("arst_comp", int'(compressor_on), 0);
        chk("arst_fault", int'(fault), 0);
        chk("arst_state", int'(state), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int comp_n;
        int trail_n;
        int hold_n;
        bit seen;
        n_checks = 0;
        n_err    = 0;
        reset = 1'b1;
        heat  = 1'b0;
        cool  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_fan", int'(fan_on), 0);
        chk("rst_heater", int'(heater_on), 0);
        chk("rst_comp", int'(compressor_on), 0);
        chk("rst_fault", int'(fault), 0);

        // Heat held: fan after one edge, heater two edges later.
        step_cycle(1'b1, 1'b0);
        chk("lead_fan", int'(fan_on), 1);
        chk("lead_state", int'(state), 1);
        step_cycle(1'b1, 1'b0);
        chk("lead2_heater", int'(heater_on), 0);
        step_cycle(1'b1, 1'b0);
        chk("run_heater", int'(heater_on), 1);
        chk("run_comp", int'(compressor_on), 0);
        chk("run_state", int'(state), 2);
        for (int i = 0; i < 20; i++) step_cycle(1'b1, 1'b0);

        // Heat to cool: trail 4 + hold 6 + idle 1 + lead 2 edges before compressor starts.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step_cycle(1'b0, 1'b1);
            n++;
            if (compressor_on) break;
        end
        chk("switch_latency", n, 14);
        idle_out(40);
        chk("switch_idle", int'(state), 0);

        // Single-cycle cool pulse: 8 run, 4 trail, 6 hold.
        step_cycle(1'b0, 1'b1);
        comp_n = 0; trail_n = 0; hold_n = 0; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_cycle(1'b0, 1'b0);
            if (compressor_on) begin comp_n++; seen = 1'b1; end
            if (seen && fan_on && !compressor_on && !heater_on) trail_n++;
            if (state == 3'd4) hold_n++;
        end
        chk("pulse_run_len", comp_n, 8);
        chk("pulse_trail_len", trail_n, 4);
        chk("pulse_hold_len", hold_n, 6);

        // Re-request pulsed during HOLD is ignored.
        step_cycle(1'b0, 1'b1);
        for (int i = 0; i < 40 && state != 3'd4; i++) step_cycle(1'b0, 1'b0);
        step_cycle(1'b0, 1'b1);
        idle_out(10);
        chk("hold_ignore_state", int'(state), 0);
        chk("hold_ignore_fan", int'(fan_on), 0);

        // Request held through HOLD restarts right after the IDLE cycle.
        step_cycle(1'b0, 1'b1);
        for (int i = 0; i < 40 && state != 3'd4; i++) step_cycle(1'b0, 1'b0);
        for (int i = 0; i < 20 && state != 3'd0; i++) step_cycle(1'b0, 1'b1);
        step_cycle(1'b0, 1'b1);
        chk("held_restart_state", int'(state), 1);
        idle_out(40);

        // Both requests: fault, no drive.
        for (int i = 0; i < 5; i++) begin
            step_cycle(1'b1, 1'b1);
            chk("both_fault", int'(fault), 1);
            chk("both_state", int'(state), 0);
            chk("both_fan", int'(fan_on), 0);
        end
        step_cycle(1'b0, 1'b0);
        chk("both_fault_clear", int'(fault), 0);

        // Async reset mid-RUN, then immediate restart with no lockout.
        for (int i = 0; i < 5; i++) step_cycle(1'b0, 1'b1);
        async_reset();
        step_cycle(1'b0, 1'b1);
        chk("post_rst_state", int'(state), 1);
        chk("post_rst_fan", int'(fan_on), 1);
        idle_out(40);

`ifdef HVAC_START_CNT_EN
        async_reset();
        for (int r = 0; r < 3; r++) begin
            step_cycle(1'b1, 1'b0);
            idle_out(30);
        end
        chk("start_count_3", int'(start_count), 3);
        async_reset();
        chk("start_count_rst", int'(start_count), 0);
`endif

        // Randomized requests with occasional asynchronous resets.
        pat = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) pat = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) async_reset();
            else step_cycle(pat[1], pat[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
